fetch_prefetch_buffer: RTL and testbench
========================================

Name: fetch_prefetch_buffer

Overview:
- Upstream neighbour of the fetch_to_decode pipeline register; replaces the combinational instruction-memory lookup.
- Issues in-order requests to a latency-tolerant instruction memory over a valid/ready request channel and a valid-only response channel.
- Buffers returned words with their PCs in a small FIFO and presents them to decode.
- Handles branch redirects by flushing the FIFO and discarding stale in-flight responses.

Parameters:
- DEPTH, 4, FIFO entries and maximum outstanding-plus-buffered requests (power of 2, >=2).
- XLEN, 32, address and instruction width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clock  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- imem_req_valid  out  1  request to instruction memory.
- imem_req_ready  in  1  memory accepts request this cycle.
- imem_req_addr  out  XLEN  word-aligned fetch address.
- imem_rsp_valid  in  1  response word valid; responses return in request order, no backpressure.
- imem_rsp_data  in  XLEN  returned instruction.
- redirect  in  1  branch taken (br_taken from execute).
- redirect_pc  in  XLEN  branch target (ALU result).
- stall  in  1  decode cannot accept this cycle.
- inst_valid  out  1  FIFO head valid for decode.
- inst  out  XLEN  head instruction.
- inst_pc  out  XLEN  PC of head instruction.

Behaviour:
- Reset (async assert) sets:
  - fetch_pc = RESET_PC and rsp_pc = RESET_PC.
  - FIFO empty, outstanding = 0, discard = 0, state = FETCH.
  - imem_req_valid = 0, inst_valid = 0, inst = 0, inst_pc = 0.
- First request is issued in the first clock cycle after reset deassertion.
- State machine: FETCH, FLUSH.
- Request issue:
  - imem_req_valid = (state == FETCH) && !redirect && (fifo_count + outstanding < DEPTH).
  - imem_req_addr = fetch_pc.
  - req_fire = imem_req_valid && imem_req_ready.
  - On req_fire: fetch_pc += 4 and outstanding += 1.
- Address change on redirect: imem_req_addr may change while imem_req_valid is high without ready; this is permitted only through the redirect path, because the memory interface is internal.
- Response handling:
  - Every imem_rsp_valid decrements outstanding.
  - If discard > 0, the response is dropped and discard decrements.
  - Otherwise {rsp_pc, imem_rsp_data} is pushed and rsp_pc += 4.
  - Credits guarantee no push into a full FIFO; an overflow is an assertion failure.
- Consume:
  - inst_valid = fifo nonempty && !redirect.
  - Pop when inst_valid && !stall.
  - A pop does not free a credit until the following cycle, because credits use registered fifo_count.
- Latency: with a zero-wait memory (ready = 1, response next cycle), the first inst_valid appears 2 cycles after reset release; sustained throughput is 1 instruction/cycle.
- Redirect (highest priority, any state):
  - FIFO cleared at the edge; fetch_pc and rsp_pc are set to redirect_pc.
  - No request is issued and no pop occurs in the redirect cycle.
  - discard_next = outstanding + req_fire − rsp_fire, where req_fire = 0 by the issue rule. A same-cycle response counts as stale and is dropped.
  - State becomes FLUSH if discard_next > 0, else FETCH.
- FLUSH:
  - No requests issued.
  - Transition to FETCH in the cycle after discard reaches 0.
  - A redirect during FLUSH only updates fetch_pc and rsp_pc; discard is unaffected.
- Simultaneous push and pop: both occur; count unchanged.
- A pop on a single-entry FIFO with a same-cycle push yields the new head next cycle.
- PC wrap: +4 past 32'hFFFF_FFFC wraps to 0 with no flag.
- Reset mid-operation: all state returns to reset values immediately. Responses to pre-reset requests are the memory model's responsibility, and the memory is reset together with this block.

Decomposition:
- Shared package fetch_pkg holds:
  - XLEN and RESET_PC constants.
  - fetch_state_e enum {FETCH, FLUSH}.
  - fetch_entry_t struct {pc, inst}.
- Sub-module fetch_fifo: synchronous FIFO of fetch_entry_t with DEPTH, push, pop, flush, count, head outputs, and async active-high reset.
- Top block holds the FSM, credit logic, outstanding/discard counters, and PC registers.

Test Plan:
- Zero-wait memory returning word = addr, stall = 0, release reset → inst_valid first high 2 cycles after release; inst/inst_pc sequence is 0x0, 0x4, 0x8, … one per cycle.
- Hold stall = 1 for 10 cycles → at most DEPTH = 4 entries buffered, imem_req_valid drops, no words lost; after release, PCs continue consecutively.
- Memory with 3-cycle latency, 2 requests outstanding, assert redirect with redirect_pc = 0x100 → state enters FLUSH, 2 responses dropped, first delivered inst_pc = 0x100.
- Redirect in the same cycle as imem_rsp_valid → that response is dropped; inst_valid is low in the redirect cycle.
- imem_req_ready randomly low 50% of cycles over 200 instructions → delivered PCs are strictly sequential with no duplicates or gaps.
- Assert reset for 1 cycle mid-stream with 3 entries buffered → outputs zero immediately and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction prefetch buffer.
// Each buffered entry pairs a returned instruction word with its fetch PC.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

  typedef enum logic {
    FETCH,
    FLUSH
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with flush; flush wins over push and pop.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             push_entry,
  output logic [$clog2(DEPTH):0]   count,
  output fetch_entry_t             head
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && ((count_q != (AW+1)'(DEPTH)) || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_entry;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  no_overflow: assert property (@(posedge clock) disable iff (reset)
    !(push && !flush && !do_pop && (count_q == (AW+1)'(DEPTH))));

endmodule

// File: rtl/fetch_prefetch_buffer.sv
// Prefetching fetch stage: issues in-order memory requests under a credit limit,
// buffers returned words with their PCs, and flushes/discards stale data on redirect.
module fetch_prefetch_buffer #(
  parameter int               DEPTH    = 4,
  parameter int               XLEN     = fetch_pkg::XLEN,
  parameter logic [XLEN-1:0]  RESET_PC = fetch_pkg::RESET_PC
) (
  input  logic            clock,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall,
  output logic            inst_valid,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc
);

  import fetch_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   discard_q, discard_d;
  logic [CW-1:0]   fifo_count;
  logic [CW:0]     credits_used;
  logic            req_fire, rsp_fire, rsp_keep, pop;
  fetch_entry_t    push_entry, head;

  // Credits count registered FIFO occupancy, so a pop frees its slot one cycle later.
  assign credits_used = {1'b0, fifo_count} + {1'b0, outstanding_q};
  assign req_fire     = imem_req_valid && imem_req_ready;
  assign rsp_fire     = imem_rsp_valid;
  assign rsp_keep     = rsp_fire && !redirect && (discard_q == '0);
  assign pop          = inst_valid && !stall;
  assign push_entry   = '{pc: rsp_pc_q, inst: imem_rsp_data};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == FETCH) begin
      if (redirect && (discard_d != '0)) begin
        state_d = FLUSH;
      end
    end else if (discard_q == '0) begin
      state_d = FETCH;
    end
  end

  // Request is held low during reset so nothing is issued before the first live edge.
  always_comb begin
    imem_req_valid = !reset && (state_q == FETCH) && !redirect &&
                     (credits_used < (CW+1)'(DEPTH));
    inst_valid     = (fifo_count != '0) && !redirect;
  end

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    discard_d     = discard_q;
    outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_fire);
    if (req_fire) begin
      fetch_pc_d = fetch_pc_q + XLEN'(4);
    end
    if (rsp_keep) begin
      rsp_pc_d = rsp_pc_q + XLEN'(4);
    end
    if (rsp_fire && (discard_q != '0)) begin
      discard_d = discard_q - CW'(1);
    end
    // In FLUSH every outstanding response is already marked stale, so only the PCs move.
    if (redirect) begin
      fetch_pc_d = redirect_pc;
      rsp_pc_d   = redirect_pc;
      if (state_q == FETCH) begin
        discard_d = outstanding_q - CW'(rsp_fire);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (rsp_keep),
    .pop        (pop),
    .flush      (redirect),
    .push_entry (push_entry),
    .count      (fifo_count),
    .head       (head)
  );

  assign imem_req_addr = fetch_pc_q;
  assign inst          = head.inst;
  assign inst_pc       = head.pc;

endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// Scoreboard bench for fetch_prefetch_buffer: a latency-configurable memory model
// returns word = address, and a monitor checks every delivered instruction in order.
module tb_fetch_prefetch_buffer;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  pend_t       pend_q[$];
  int          lat = 1;
  int          ready_mode = 0;
  int          cyc = 0;
  logic [31:0] mon_exp;

  always #5 clock = ~clock;

  fetch_prefetch_buffer dut (
    .clock          (clock),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  // Drive redirect/stall and the memory ready mode (0 always, 1 random, 2 never) at a falling edge.
  task automatic applyStimulus(input logic rd, input logic [31:0] rpc, input logic st, input int rm);
    @(negedge clock);
    redirect    = rd;
    redirect_pc = rpc;
    stall       = st;
    ready_mode  = rm;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic expectRange(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  task automatic waitDrain(input string name, input int bound);
    for (int i = 0; i < bound && exp_q.size() != 0; i++) @(negedge clock);
    checkOutput(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic measureFirstValid(input string name);
    int n = 0;
    while (!inst_valid && n < 10) begin
      @(posedge clock);
      #1;
      n++;
    end
    checkOutput(name, 32'(n), 32'd2);
  endtask

  // In-order memory: accepts at the edge ending cycle cyc, responds in cycle cyc+lat.
  initial begin
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(negedge clock);
      #1;
      if (reset) pend_q.delete();
      case (ready_mode)
        0:       imem_req_ready = 1'b1;
        1:       imem_req_ready = 1'($urandom_range(0, 1));
        default: imem_req_ready = 1'b0;
      endcase
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = pend_q[0].addr;
        void'(pend_q.pop_front());
      end
      #2;
      if (reset) pend_q.delete();
      else if (imem_req_valid && imem_req_ready)
        pend_q.push_back('{addr: imem_req_addr, due: cyc + lat});
      cyc++;
    end
  end

  // Monitor: every accepted instruction must match the next expected PC (word = PC).
  initial begin
    forever begin
      @(negedge clock);
      #3;
      if (!reset && inst_valid && !stall && exp_q.size() > 0) begin
        mon_exp = exp_q.pop_front();
        checkOutput("inst_pc", inst_pc, mon_exp);
        checkOutput("inst", inst, mon_exp);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset       = 1'b1;
    redirect    = 1'b0;
    redirect_pc = '0;
    stall       = 1'b0;
    #12;
    checkOutput("reset_req_valid", 32'(imem_req_valid), 32'd0);
    checkOutput("reset_inst_valid", 32'(inst_valid), 32'd0);
    checkOutput("reset_inst", inst, 32'd0);
    checkOutput("reset_inst_pc", inst_pc, 32'd0);

    // Zero-wait memory, sequential stream from RESET_PC.
    expectRange(32'h0, 16);
    @(negedge clock);
    reset = 1'b0;
    measureFirstValid("first_valid_latency");
    waitDrain("drain_seq", 100);

    // Stall with buffer full: requests stop, nothing lost afterwards.
    applyStimulus(1'b1, 32'h200, 1'b1, 0);
    applyStimulus(1'b0, 32'h0, 1'b1, 0);
    idle(10);
    #2;
    checkOutput("stall_req_valid", 32'(imem_req_valid), 32'd0);
    checkOutput("stall_head_valid", 32'(inst_valid), 32'd1);
    checkOutput("stall_head_pc", inst_pc, 32'h200);
    expectRange(32'h200, 16);
    applyStimulus(1'b0, 32'h0, 1'b0, 0);
    waitDrain("drain_stall", 100);

    // Three-cycle memory, two requests in flight at redirect to 0x100.
    applyStimulus(1'b0, 32'h0, 1'b1, 2);
    idle(8);
    lat = 3;
    applyStimulus(1'b1, 32'h800, 1'b1, 2);
    applyStimulus(1'b0, 32'h0, 1'b1, 2);
    idle(2);
    applyStimulus(1'b0, 32'h0, 1'b1, 0);
    applyStimulus(1'b0, 32'h0, 1'b1, 0);
    applyStimulus(1'b1, 32'h100, 1'b1, 2);
    #2;
    checkOutput("redir_inst_valid", 32'(inst_valid), 32'd0);
    checkOutput("redir_req_valid", 32'(imem_req_valid), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 0);
    expectRange(32'h100, 8);
    #2;
    checkOutput("flush_req_valid", 32'(imem_req_valid), 32'd0);
    waitDrain("drain_flush", 100);

    // Redirect in the same cycle as a response in a steady stream.
    applyStimulus(1'b0, 32'h0, 1'b1, 0);
    idle(10);
    lat = 1;
    applyStimulus(1'b0, 32'h0, 1'b0, 0);
    idle(6);
    #2;
    checkOutput("stream_valid", 32'(inst_valid), 32'd1);
    applyStimulus(1'b1, 32'h300, 1'b0, 0);
    #2;
    checkOutput("redir_rsp_inst_valid", 32'(inst_valid), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 0);
    expectRange(32'h300, 8);
    waitDrain("drain_redir_rsp", 100);

    // Random request backpressure over 200 instructions.
    applyStimulus(1'b1, 32'h400, 1'b0, 0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1);
    expectRange(32'h400, 200);
    waitDrain("drain_random", 3000);

    // PC wrap past the top of the address space.
    applyStimulus(1'b1, 32'hFFFF_FFF8, 1'b0, 0);
    applyStimulus(1'b0, 32'h0, 1'b0, 0);
    expectRange(32'hFFFF_FFF8, 6);
    waitDrain("drain_wrap", 100);

    // Reset mid-stream with three entries buffered.
    applyStimulus(1'b0, 32'h0, 1'b1, 2);
    idle(5);
    applyStimulus(1'b1, 32'h500, 1'b1, 2);
    applyStimulus(1'b0, 32'h0, 1'b1, 2);
    idle(2);
    applyStimulus(1'b0, 32'h0, 1'b1, 0);
    applyStimulus(1'b0, 32'h0, 1'b1, 0);
    applyStimulus(1'b0, 32'h0, 1'b1, 0);
    applyStimulus(1'b0, 32'h0, 1'b1, 2);
    idle(3);
    #2;
    checkOutput("pre_reset_valid", 32'(inst_valid), 32'd1);
    checkOutput("pre_reset_head", inst_pc, 32'h500);
    reset = 1'b1;
    #1;
    checkOutput("mid_reset_req_valid", 32'(imem_req_valid), 32'd0);
    checkOutput("mid_reset_inst_valid", 32'(inst_valid), 32'd0);
    checkOutput("mid_reset_inst", inst, 32'd0);
    checkOutput("mid_reset_inst_pc", inst_pc, 32'd0);
    expectRange(32'h0, 8);
    @(negedge clock);
    reset      = 1'b0;
    stall      = 1'b0;
    ready_mode = 0;
    measureFirstValid("restart_latency");
    waitDrain("drain_restart", 100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
